student_audio_rx_fifo: RTL and testbench
========================================

# student_audio_rx_fifo

Stereo sample buffer directly downstream of the IIS receive path. It captures each new left/right sample pair when the codec handler's valid strobe rises. It stores the pairs in a small FIFO and presents them to the filter datapath over a valid/ready stream, so that filter back-pressure never loses samples. Overflow is counted, and a synchronous flush is provided for reconfiguration.

## Interface
- DEPTH, 8, number of stereo entries; power of two, ≥ 2
- SW, 16, sample width per channel
- CNTW, 8, overflow counter width
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous flush; empties FIFO, zeroes overflow count
- smp_l_i  in  SW  left sample from IIS handler
- smp_r_i  in  SW  right sample from IIS handler
- smp_strobe_i  in  1  sample-valid level from IIS handler; new pair on each 0→1 edge
- out_valid_o  out  1  FIFO head holds a pair
- out_ready_i  in  1  consumer accepts head this cycle
- out_l_o  out  SW  head left sample
- out_r_o  out  SW  head right sample
- level_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow_o  out  1  sticky; set on first dropped pair
- ovf_cnt_o  out  CNTW  dropped-pair count, saturating at all-ones

## Operation
- Edge detect: strobe_q registers smp_strobe_i and resets to 0.
  - wr_req = smp_strobe_i & ~strobe_q, evaluated combinationally.
  - The strobe may stay high for many cycles; exactly one write is requested per rising edge.
- Storage: DEPTH×(2·SW) array with write pointer, read pointer and occupancy count.
  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - Array contents are not reset.
- Write: on wr_req with accept, {smp_l_i, smp_r_i} is written at wr_ptr, then wr_ptr increments.
  - Samples are taken in the same cycle as the edge; the handler holds them stable while its strobe is high.
- Read: on out_valid_o & out_ready_i, rd_ptr increments.
- Head data: out_l_o/out_r_o are a combinational read of mem[rd_ptr], first-word-fall-through.
  - Head data is don't-care while out_valid_o=0.
- Accept rule: a write is accepted if level < DEPTH, or if a read handshake happens in the same cycle (full with simultaneous pop).
- Level update: level +1 on write only, −1 on read only, unchanged on both or neither.
- out_valid_o = (level != 0).
- Overflow: on wr_req that is not accepted, the pair is dropped and the FIFO is unchanged.
  - overflow_o is set to 1.
  - ovf_cnt_o increments unless already all-ones.
- clear_i, highest priority:
  - Next cycle, wr_ptr = rd_ptr = level = 0, overflow_o = 0, ovf_cnt_o = 0.
  - Any wr_req or handshake in the same cycle is ignored.
  - strobe_q still updates, so a strobe that is already high does not cause a spurious write after the clear.
- Reset mid-operation: all state returns to reset values asynchronously; the FIFO is empty afterwards.

## Timing
- Reset values: out_valid_o=0, level_o=0, overflow_o=0, ovf_cnt_o=0, strobe_q=0.
  - out_l_o/out_r_o follow the array, which is uninitialised; the bench treats them as X while invalid.
- Latency: with the FIFO empty, a strobe edge at cycle n gives out_valid_o=1 and the pair on out_l_o/out_r_o at cycle n+1.
- Throughput: one write and one read per cycle, sustainable concurrently.
- Handshake: out_valid_o never drops without a handshake, except on clear_i or reset. Head data stays stable while out_valid_o=1 and out_ready_i=0.
- level_o, overflow_o and ovf_cnt_o are registered and update the cycle after the causing event.
- The nominal sample rate is far below the clock rate; back-to-back strobe edges on consecutive cycles are impossible, since an edge requires a low cycle in between.

## Test plan
- Single pair: strobe 0→1 held 20 cycles with L=0x1234, R=0xABCD, ready=0.
  - Required: exactly one write; valid=1 one cycle after the edge; head=0x1234/0xABCD; level=1.
  - Then ready=1 for 1 cycle → valid=0, level=0.
- Ordering and wrap: 3×DEPTH pairs with L=i, R=~i, ready toggling pseudo-randomly.
  - Required: output sequence equals input sequence; level never exceeds DEPTH; no overflow.
- Overflow: ready=0, DEPTH+3 strobe edges.
  - Required: level=DEPTH; overflow_o=1; ovf_cnt_o=3.
  - Then drain: pairs 0..DEPTH−1 in order; the 3 extra pairs are absent.
- Full with simultaneous pop: fill to DEPTH, then assert ready on the exact cycle of a new edge.
  - Required: new pair accepted; level stays DEPTH; overflow_o stays 0.
- Saturation and clear (CNTW=2): 5 drops while full → ovf_cnt_o=3.
  - clear_i pulse while strobe is held high → next cycle level=0, valid=0, overflow_o=0, ovf_cnt_o=0, with no write until the next 0→1 edge.
- Async reset mid-stream: assert rst_ni low between clock edges with level=4.
  - Required: outputs reach reset values immediately.
  - After release, the first new edge yields level=1 and correct data.

Source files
------------

// File: rtl/student_audio_rx_fifo.sv
// student_audio_rx_fifo
// ---------------------
// Stereo sample buffer that sits right after the IIS receive path. A new
// left/right pair is captured on every rising edge of the handler's
// sample-valid level. Pairs are held in a small FIFO and handed to the filter
// datapath over a valid/ready stream, so filter back-pressure never loses
// samples. Dropped pairs are counted, and a synchronous flush is provided for
// reconfiguration.
//
// Ports
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   clear_i       synchronous flush: empties the FIFO, zeroes overflow state
//   smp_l_i       left sample from the IIS handler
//   smp_r_i       right sample from the IIS handler
//   smp_strobe_i  sample-valid level; each 0->1 edge carries one new pair
//   out_valid_o   FIFO head holds a pair
//   out_ready_i   consumer accepts the head this cycle
//   out_l_o       head left sample (first-word-fall-through)
//   out_r_o       head right sample (first-word-fall-through)
//   level_o       current occupancy, 0..DEPTH
//   overflow_o    sticky flag, set on the first dropped pair
//   ovf_cnt_o     dropped-pair count, saturating at all-ones
//
// Output stream handshake: a pair transfers on every clock edge where
// out_valid_o and out_ready_i are both high. out_valid_o never drops without a
// transfer (except on clear_i or reset), and out_l_o/out_r_o stay stable while
// out_valid_o is high and out_ready_i is low.
module student_audio_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int SW    = 16,
    parameter int CNTW  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic [SW-1:0]            smp_l_i,
    input  logic [SW-1:0]            smp_r_i,
    input  logic                     smp_strobe_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [SW-1:0]            out_l_o,
    output logic [SW-1:0]            out_r_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [CNTW-1:0]          ovf_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [2*SW-1:0] mem [DEPTH];

    logic            strobe_q,   strobe_d;
    logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [LW-1:0]   level_q,    level_d;
    logic            overflow_q, overflow_d;
    logic [CNTW-1:0] ovf_cnt_q,  ovf_cnt_d;

    logic wr_req;
    logic rd_fire;
    logic wr_accept;
    logic mem_we;

    assign out_valid_o = (level_q != '0);
    assign out_l_o     = mem[rd_ptr_q][2*SW-1:SW];
    assign out_r_o     = mem[rd_ptr_q][SW-1:0];
    assign level_o     = level_q;
    assign overflow_o  = overflow_q;
    assign ovf_cnt_o   = ovf_cnt_q;

    // One write request per rising edge of the strobe, however long it stays high.
    assign wr_req  = smp_strobe_i & ~strobe_q;
    assign rd_fire = out_valid_o & out_ready_i;
    // A full FIFO still takes a pair when the head leaves in the same cycle.
    assign wr_accept = wr_req & ((level_q != FULL_LEVEL) | rd_fire);

    always_comb begin
        strobe_d   = smp_strobe_i;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        ovf_cnt_d  = ovf_cnt_q;
        mem_we     = 1'b0;

        if (clear_i) begin
            // Flush wins over everything; strobe_d still tracks the input so a
            // strobe held across the flush cannot produce a late write.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            ovf_cnt_d  = '0;
        end else begin
            if (wr_accept) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({wr_accept, rd_fire})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (wr_req && !wr_accept) begin
                overflow_d = 1'b1;
                if (ovf_cnt_q != {CNTW{1'b1}}) begin
                    ovf_cnt_d = ovf_cnt_q + CNTW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            strobe_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            strobe_q   <= strobe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    // Sample storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= {smp_l_i, smp_r_i};
        end
    end

endmodule

// File: tb/tb_student_audio_rx_fifo.sv
module tb_student_audio_rx_fifo;

    localparam int DEPTH = 8;
    localparam int SW    = 16;
    localparam int CNTW  = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    logic            clear_i;
    logic [SW-1:0]   smp_l_i;
    logic [SW-1:0]   smp_r_i;
    logic            smp_strobe_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [SW-1:0]   out_l_o;
    logic [SW-1:0]   out_r_o;
    logic [LW-1:0]   level_o;
    logic            overflow_o;
    logic [CNTW-1:0] ovf_cnt_o;

    student_audio_rx_fifo #(
        .DEPTH(DEPTH),
        .SW   (SW),
        .CNTW (CNTW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .smp_l_i     (smp_l_i),
        .smp_r_i     (smp_r_i),
        .smp_strobe_i(smp_strobe_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_l_o     (out_l_o),
        .out_r_o     (out_r_o),
        .level_o     (level_o),
        .overflow_o  (overflow_o),
        .ovf_cnt_o   (ovf_cnt_o)
    );

    // ---------------- scoreboard / reference state ----------------
    logic [2*SW-1:0] exp_q[$];
    logic [LW-1:0]   m_level;
    logic            m_ovf;
    logic [CNTW-1:0] m_cnt;
    logic            m_stb;
    int              n_checks;
    int              n_pass;

    task automatic model_reset();
        exp_q.delete();
        m_level = '0;
        m_ovf   = 1'b0;
        m_cnt   = '0;
        m_stb   = 1'b0;
    endtask

    // One clock cycle: inputs applied after the falling edge, registered state
    // compared against the reference, scoreboard popped on a handshake and
    // pushed on an accepted strobe edge; the DUT acts on the next rising edge.
    task automatic cycle(input logic stb, input logic [SW-1:0] l, input logic [SW-1:0] r,
                         input logic rdy, input logic clr);
        logic            wr;
        logic            fire;
        logic [2*SW-1:0] exp;
        @(negedge clk_i);
        smp_strobe_i = stb;
        smp_l_i      = l;
        smp_r_i      = r;
        out_ready_i  = rdy;
        clear_i      = clr;
        #1;
        n_checks++;
        if (level_o !== m_level) $display("FAIL level: got %0d exp %0d", level_o, m_level);
        else n_pass++;
        n_checks++;
        if (out_valid_o !== (m_level != 0)) $display("FAIL valid: got %b exp %b", out_valid_o, (m_level != 0));
        else n_pass++;
        n_checks++;
        if (overflow_o !== m_ovf) $display("FAIL overflow: got %b exp %b", overflow_o, m_ovf);
        else n_pass++;
        n_checks++;
        if (ovf_cnt_o !== m_cnt) $display("FAIL ovf_cnt: got %0d exp %0d", ovf_cnt_o, m_cnt);
        else n_pass++;

        if (clr) begin
            exp_q.delete();
            m_level = '0;
            m_ovf   = 1'b0;
            m_cnt   = '0;
        end else begin
            wr   = stb & ~m_stb;
            fire = (m_level != 0) & rdy;
            if (fire) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL pop_empty: got valid=%b exp empty scoreboard", out_valid_o);
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_l_o, out_r_o} !== exp)
                        $display("FAIL head_data: got %h/%h exp %h/%h", out_l_o, out_r_o, exp[2*SW-1:SW], exp[SW-1:0]);
                    else n_pass++;
                end
            end
            if (wr) begin
                if (m_level < DEPTH || fire) exp_q.push_back({l, r});
                else begin
                    m_ovf = 1'b1;
                    if (m_cnt != {CNTW{1'b1}}) m_cnt = m_cnt + 1'b1;
                end
            end
            if (wr && (m_level < DEPTH || fire) && !fire) m_level = m_level + 1'b1;
            else if (fire && !(wr && (m_level < DEPTH || fire))) m_level = m_level - 1'b1;
        end
        m_stb = stb;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4 * DEPTH && m_level != 0; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (exp_q.size() != 0 || level_o !== '0)
            $display("FAIL %s_drain: got level=%0d left=%0d exp 0/0", tag, level_o, exp_q.size());
        else n_pass++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_ni = 1'b0; clear_i = 1'b0; smp_strobe_i = 1'b0;
        smp_l_i = '0; smp_r_i = '0; out_ready_i = 1'b0;
        model_reset();
        #3;
        n_checks++;
        if (out_valid_o !== 1'b0 || level_o !== '0 || overflow_o !== 1'b0 || ovf_cnt_o !== '0)
            $display("FAIL reset_state: got v=%b l=%0d o=%b c=%0d exp 0/0/0/0", out_valid_o, level_o, overflow_o, ovf_cnt_o);
        else n_pass++;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_single_pair();
        cycle(1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b0);
        cycle(1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b0);
        n_checks++;
        if (out_valid_o !== 1'b1 || out_l_o !== 16'h1234 || out_r_o !== 16'hABCD || level_o !== 1)
            $display("FAIL single_latency: got v=%b %h/%h l=%0d exp 1 1234/abcd 1", out_valid_o, out_l_o, out_r_o, level_o);
        else n_pass++;
        repeat (18) cycle(1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b0);
        n_checks++;
        if (level_o !== 1) $display("FAIL single_one_write: got level=%0d exp 1", level_o);
        else n_pass++;
        cycle(1'b1, 16'h1234, 16'hABCD, 1'b1, 1'b0);
        cycle(1'b0, 16'h1234, 16'hABCD, 1'b0, 1'b0);
        n_checks++;
        if (out_valid_o !== 1'b0 || level_o !== 0)
            $display("FAIL single_pop: got v=%b l=%0d exp 0/0", out_valid_o, level_o);
        else n_pass++;
    endtask

    task automatic test_order_wrap();
        logic [SW-1:0] v;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            v = SW'(i);
            cycle(1'b1, v, ~v, ($urandom_range(0, 3) != 0), 1'b0);
            cycle(1'b0, v, ~v, ($urandom_range(0, 3) != 0), 1'b0);
            n_checks++;
            if (level_o > DEPTH) $display("FAIL order_level_bound: got %0d exp <= %0d", level_o, DEPTH);
            else n_pass++;
        end
        n_checks++;
        if (overflow_o !== 1'b0) $display("FAIL order_no_overflow: got %b exp 0", overflow_o);
        else n_pass++;
        drain("order");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 3; i++) begin
            cycle(1'b1, SW'(16'h0100 + i), SW'(16'h0200 + i), 1'b0, 1'b0);
            cycle(1'b0, SW'(16'h0100 + i), SW'(16'h0200 + i), 1'b0, 1'b0);
        end
        n_checks++;
        if (level_o !== DEPTH || overflow_o !== 1'b1 || ovf_cnt_o !== 3)
            $display("FAIL overflow_state: got l=%0d o=%b c=%0d exp %0d/1/3", level_o, overflow_o, ovf_cnt_o, DEPTH);
        else n_pass++;
        drain("overflow");
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, SW'(16'h3000 + i), SW'(16'h4000 + i), 1'b0, 1'b0);
            cycle(1'b0, '0, '0, 1'b0, 1'b0);
        end
        cycle(1'b1, 16'h5A5A, 16'hA5A5, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (level_o !== DEPTH || overflow_o !== 1'b0)
            $display("FAIL full_pop: got l=%0d o=%b exp %0d/0", level_o, overflow_o, DEPTH);
        else n_pass++;
        drain("full_pop");
    endtask

    task automatic test_sat_clear();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, SW'(16'h6000 + i), SW'(16'h7000 + i), 1'b0, 1'b0);
            cycle(1'b0, '0, '0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
            cycle(1'b0, '0, '0, 1'b0, 1'b0);
        end
        cycle(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
        cycle(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
        n_checks++;
        if (ovf_cnt_o !== 3 || overflow_o !== 1'b1)
            $display("FAIL saturate: got c=%0d o=%b exp 3/1", ovf_cnt_o, overflow_o);
        else n_pass++;
        cycle(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b1);
        cycle(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
        n_checks++;
        if (level_o !== 0 || out_valid_o !== 1'b0 || overflow_o !== 1'b0 || ovf_cnt_o !== 0)
            $display("FAIL clear: got l=%0d v=%b o=%b c=%0d exp 0/0/0/0", level_o, out_valid_o, overflow_o, ovf_cnt_o);
        else n_pass++;
        repeat (3) cycle(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
        n_checks++;
        if (level_o !== 0) $display("FAIL clear_no_spurious: got level=%0d exp 0", level_o);
        else n_pass++;
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0F0F, 16'hF0F0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (level_o !== 1 || out_l_o !== 16'h0F0F || out_r_o !== 16'hF0F0)
            $display("FAIL clear_next_edge: got l=%0d %h/%h exp 1 0f0f/f0f0", level_o, out_l_o, out_r_o);
        else n_pass++;
        drain("sat_clear");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, SW'(16'h8000 + i), SW'(16'h9000 + i), 1'b0, 1'b0);
            cycle(1'b0, '0, '0, 1'b0, 1'b0);
        end
        n_checks++;
        if (level_o !== 4) $display("FAIL async_pre: got level=%0d exp 4", level_o);
        else n_pass++;
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (out_valid_o !== 1'b0 || level_o !== '0 || overflow_o !== 1'b0 || ovf_cnt_o !== '0)
            $display("FAIL async_reset: got v=%b l=%0d o=%b c=%0d exp 0/0/0/0", out_valid_o, level_o, overflow_o, ovf_cnt_o);
        else n_pass++;
        smp_strobe_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        cycle(1'b1, 16'h5555, 16'hAAAA, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (level_o !== 1 || out_l_o !== 16'h5555 || out_r_o !== 16'hAAAA)
            $display("FAIL async_after: got l=%0d %h/%h exp 1 5555/aaaa", level_o, out_l_o, out_r_o);
        else n_pass++;
        drain("async");
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_single_pair();
        test_order_wrap();
        test_overflow();
        test_full_pop();
        test_sat_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
